uart_rx_sampler: RTL and testbench

16x-oversampling UART receiver that converts the serial `rx_data` line back into bytes; it is the receive-side counterpart of the team's transmitter and consumes the same `sel_baud` encoding. It sits between the pad/loopback net and the byte consumer, and presents each received byte on a valid/ready handshake. The block flags framing and overrun errors.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_baud_tick.sv | 50 +++++
 rtl/uart_rx_sampler.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud select encoding, divisor helper and receiver FSM states.
// The parity-related state is only reachable in builds that define UART_RX_PARITY_EN.
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;

   typedef enum logic [1:0] {
      B4800   = 2'b00,
      B9600   = 2'b01,
      B19200  = 2'b10,
      B115200 = 2'b11
   } baud_sel_e;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } rx_state_e;

   // Rounded divisor so the oversample tick lands as close as possible to baud*16.
   function automatic int unsigned baud_div(input int unsigned clk_hz, input baud_sel_e sel);
      int unsigned baud;
      case (sel)
         B4800:   baud = 4800;
         B9600:   baud = 9600;
         B19200:  baud = 19200;
         default: baud = 115200;
      endcase
      return (clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every baud_div(CLK_HZ, sel) cycles while enabled.
// The divisors are elaboration-time constants, so only a small mux and a counter are built.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000
)
(
   input  logic      sys_clk,
   input  logic      rst,
   input  baud_sel_e sel,
   input  logic      restart,
   input  logic      enable,
   output logic      tick
);

   localparam int unsigned DIV_4800   = baud_div(CLK_HZ, B4800);
   localparam int unsigned DIV_9600   = baud_div(CLK_HZ, B9600);
   localparam int unsigned DIV_19200  = baud_div(CLK_HZ, B19200);
   localparam int unsigned DIV_115200 = baud_div(CLK_HZ, B115200);

   logic [31:0] div_m1;
   logic [31:0] count;

   always_comb begin
      div_m1 = 32'(DIV_115200 - 1);
      case (sel)
         B4800:   div_m1 = 32'(DIV_4800 - 1);
         B9600:   div_m1 = 32'(DIV_9600 - 1);
         B19200:  div_m1 = 32'(DIV_19200 - 1);
         default: div_m1 = 32'(DIV_115200 - 1);
      endcase
   end

   // Restart zeroes the phase so ticks are aligned to the detected start edge.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (restart || !enable) begin
         count <= '0;
      end else if (count >= div_m1) begin
         count <= '0;
      end else begin
         count <= count + 32'd1;
      end
   end

   assign tick = enable && !restart && (count >= div_m1);

endmodule

// File: rtl/uart_rx_sampler.sv
// 16x oversampling UART receiver with valid/ready byte output, framing and overrun pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output (default is 8N1).
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned OVERSAMPLE = 16
)
(
   input  logic       sys_clk,
   input  logic       rst,
   input  logic [1:0] sel_baud,
   input  logic       rx_data,
   output logic [7:0] rx_d_out,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_status,
   output logic       frame_err,
   output logic       overrun
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   logic      sync1;
   logic      rxs;
   logic      rxs_prev;
   rx_state_e state;
   baud_sel_e sel_lat;
   logic [3:0] scnt;
   logic [2:0] bcnt;
   logic      s7;
   logic      s8;
   logic      samp_bit;
   logic [7:0] shreg;
   logic      tick;
   logic      start_det;
   logic      maj;
   logic      last_tick;
   logic      stop_eval;
   logic      deliver;
`ifdef UART_RX_PARITY_EN
   logic      par_bit;
   logic      par_bad;
`endif

   // Two-flop synchronizer plus one history flop for falling-edge detection; all idle high.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         sync1    <= 1'b1;
         rxs      <= 1'b1;
         rxs_prev <= 1'b1;
      end else begin
         sync1    <= rx_data;
         rxs      <= sync1;
         rxs_prev <= rxs;
      end
   end

   assign start_det = (state == IDLE) && rxs_prev && !rxs;
   assign maj       = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
   assign last_tick = (scnt == 4'(OVERSAMPLE - 1));
   assign stop_eval = tick && (state == STOP) && (scnt == 4'd9);
   assign rx_status = (state != IDLE);

`ifdef UART_RX_PARITY_EN
   assign par_bad = ^{shreg, par_bit};
   assign deliver = stop_eval && maj && !par_bad;
`else
   assign deliver = stop_eval && maj;
`endif

   uart_baud_tick #(
      .CLK_HZ (CLK_HZ)
   ) u_tick (
      .sys_clk (sys_clk),
      .rst     (rst),
      .sel     (sel_lat),
      .restart (start_det),
      .enable  (rx_status),
      .tick    (tick)
   );

   // Frame FSM; the majority of samples 7/8/9 is formed on the scnt=9 tick and used at scnt=15.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         sel_lat  <= B4800;
         scnt     <= '0;
         bcnt     <= '0;
         s7       <= 1'b1;
         s8       <= 1'b1;
         samp_bit <= 1'b1;
         shreg    <= '0;
`ifdef UART_RX_PARITY_EN
         par_bit  <= 1'b0;
`endif
      end else if (start_det) begin
         state   <= START;
         sel_lat <= baud_sel_e'(sel_baud);
         scnt    <= '0;
         bcnt    <= '0;
      end else if (tick) begin
         scnt <= scnt + 4'd1;
         if (scnt == 4'd7) s7 <= rxs;
         if (scnt == 4'd8) s8 <= rxs;
         if (scnt == 4'd9) samp_bit <= maj;
         case (state)
            START: begin
               if (scnt == 4'd9 && maj) begin
                  state <= IDLE;
               end else if (last_tick) begin
                  state <= DATA;
                  bcnt  <= '0;
               end
            end
            DATA: begin
               if (last_tick) begin
                  shreg <= {samp_bit, shreg[7:1]};
                  bcnt  <= bcnt + 3'd1;
                  if (bcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (last_tick) begin
                  par_bit <= samp_bit;
                  state   <= STOP;
               end
            end
`endif
            STOP: begin
               if (scnt == 4'd9) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Holding register: a new byte is taken only if the slot is empty or being consumed now.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         rx_d_out   <= 8'h00;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         frame_err  <= stop_eval && !maj;
         overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= stop_eval && par_bad;
`endif
         if (deliver) begin
            if (!rx_valid || rx_ready) begin
               rx_d_out <= shreg;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed self-checking bench for uart_rx_sampler, run at a UART-friendly clock so divisors are small.
// Builds with or without UART_RX_PARITY_EN; the parity frames and checks follow the macro.
module tb_uart_rx_sampler;
   import uart_pkg::*;

   localparam int unsigned TB_CLK_HZ = 3_686_400;
   localparam int DIV_4800   = 48;
   localparam int DIV_9600   = 24;
   localparam int DIV_115200 = 2;
`ifdef UART_RX_PARITY_EN
   localparam int STOP_TICK = 170;
`else
   localparam int STOP_TICK = 154;
`endif

   logic       sys_clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] sel_baud = 2'b01;
   logic       rx_data = 1'b1;
   logic [7:0] rx_d_out;
   logic       rx_valid;
   logic       rx_ready = 1'b1;
   logic       rx_status;
   logic       frame_err;
   logic       overrun;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   int checks = 0;
   int fails = 0;
   int cyc = 0;
   int frame_start_cyc = 0;

   int valid_rises = 0;
   int frame_errs = 0;
   int overruns = 0;
   int parity_errs = 0;
   int status_cycles = 0;
   int status_rise_cyc = 0;
   int valid_rise_cyc = 0;
   logic [7:0] last_byte = 8'h00;
   logic valid_q = 1'b0;
   logic status_q = 1'b0;

   int v0, f0, o0, p0, s0;

   uart_rx_sampler #(
      .CLK_HZ     (TB_CLK_HZ),
      .OVERSAMPLE (16)
   ) dut (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .sel_baud  (sel_baud),
      .rx_data   (rx_data),
      .rx_d_out  (rx_d_out),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .rx_status (rx_status),
      .frame_err (frame_err),
      .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   // Event monitor sampled on the falling edge, away from the active edge.
   always @(negedge sys_clk) begin
      if (rx_valid && !valid_q) begin
         valid_rises++;
         valid_rise_cyc = cyc;
         last_byte = rx_d_out;
      end
      if (rx_status && !status_q) status_rise_cyc = cyc;
      if (rx_status) status_cycles++;
      if (frame_err) frame_errs++;
      if (overrun) overruns++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) parity_errs++;
`endif
      valid_q  = rx_valid;
      status_q = rx_status;
   end

   task automatic checkOutput(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic takeSnapshot();
      v0 = valid_rises;
      f0 = frame_errs;
      o0 = overruns;
      p0 = parity_errs;
      s0 = status_cycles;
   endtask

   task automatic driveBit(input logic b, input int n);
      rx_data = b;
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      driveBit(1'b1, n);
   endtask

   // One complete frame; par_flip inverts the even-parity bit when parity is compiled in.
   task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                input logic par_flip, input int div);
      int bit_cyc;
      bit_cyc = 16 * div;
      frame_start_cyc = cyc;
      driveBit(1'b0, bit_cyc);
      for (int i = 0; i < 8; i++) driveBit(data[i], bit_cyc);
`ifdef UART_RX_PARITY_EN
      driveBit((^data) ^ par_flip, bit_cyc);
`endif
      driveBit(stop_bit, bit_cyc);
      rx_data = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      $display("[TB] starting uart_rx_sampler bench");
      repeat (3) @(negedge sys_clk);
      checkOutput("reset rx_d_out", int'(rx_d_out), 0);
      checkOutput("reset rx_valid", int'(rx_valid), 0);
      checkOutput("reset rx_status", int'(rx_status), 0);
      checkOutput("reset frame_err", int'(frame_err), 0);
      checkOutput("reset overrun", int'(overrun), 0);

      checkOutput("div 100M 4800", int'(baud_div(100_000_000, B4800)), 1302);
      checkOutput("div 100M 9600", int'(baud_div(100_000_000, B9600)), 651);
      checkOutput("div 100M 19200", int'(baud_div(100_000_000, B19200)), 326);
      checkOutput("div 100M 115200", int'(baud_div(100_000_000, B115200)), 54);

      @(posedge sys_clk);
      #1 rst = 1'b1;
      idleCycles(20);

      // Basic receive at 9600 with the consumer always ready.
      sel_baud = 2'b01;
      rx_ready = 1'b1;
      takeSnapshot();
      applyStimulus(8'hA5, 1'b1, 1'b0, DIV_9600);
      idleCycles(2 * 16 * DIV_9600);
      checkOutput("basic valid count", valid_rises - v0, 1);
      checkOutput("basic byte", int'(last_byte), 'hA5);
      checkOutput("basic frame_err", frame_errs - f0, 0);
      checkOutput("basic overrun", overruns - o0, 0);
      checkOutput("start latency", status_rise_cyc - frame_start_cyc, 3);
      checkOutput("basic status cycles", status_cycles - s0, STOP_TICK * DIV_9600);
      checkOutput("basic valid timing", valid_rise_cyc - status_rise_cyc, STOP_TICK * DIV_9600);
      checkOutput("basic valid consumed", int'(rx_valid), 0);

      // False start: 4-tick low glitch.
      takeSnapshot();
      driveBit(1'b0, 4 * DIV_9600);
      idleCycles(2 * 16 * DIV_9600);
      checkOutput("false start valid", valid_rises - v0, 0);
      checkOutput("false start status cycles", status_cycles - s0, 10 * DIV_9600);
      checkOutput("false start frame_err", frame_errs - f0, 0);

      // Framing error at 115200, then a good frame.
      sel_baud = 2'b11;
      takeSnapshot();
      applyStimulus(8'h3C, 1'b0, 1'b0, DIV_115200);
      idleCycles(2 * 16 * DIV_115200);
      checkOutput("framing frame_err", frame_errs - f0, 1);
      checkOutput("framing no valid", valid_rises - v0, 0);
      applyStimulus(8'hC3, 1'b1, 1'b0, DIV_115200);
      idleCycles(2 * 16 * DIV_115200);
      checkOutput("post-framing valid", valid_rises - v0, 1);
      checkOutput("post-framing byte", int'(last_byte), 'hC3);
      checkOutput("post-framing frame_err", frame_errs - f0, 1);

      // Overrun: consumer stalled across two back-to-back frames.
      sel_baud = 2'b01;
      rx_ready = 1'b0;
      takeSnapshot();
      applyStimulus(8'h11, 1'b1, 1'b0, DIV_9600);
      applyStimulus(8'h22, 1'b1, 1'b0, DIV_9600);
      idleCycles(16 * DIV_9600);
      @(negedge sys_clk);
      checkOutput("overrun held byte", int'(rx_d_out), 'h11);
      checkOutput("overrun held valid", int'(rx_valid), 1);
      checkOutput("overrun pulses", overruns - o0, 1);
      checkOutput("overrun valid count", valid_rises - v0, 1);
      @(posedge sys_clk);
      #1 rx_ready = 1'b1;
      @(posedge sys_clk);
      #1 rx_ready = 1'b0;
      @(negedge sys_clk);
      checkOutput("overrun drained valid", int'(rx_valid), 0);
      checkOutput("overrun drained byte", int'(rx_d_out), 'h11);

      // Reset in the middle of data bit 3 of 8'hFF.
      rx_ready = 1'b1;
      driveBit(1'b0, 16 * DIV_9600);
      for (int i = 0; i < 3; i++) driveBit(1'b1, 16 * DIV_9600);
      driveBit(1'b1, 8 * DIV_9600);
      rst = 1'b0;
      @(negedge sys_clk);
      checkOutput("midreset rx_d_out", int'(rx_d_out), 0);
      checkOutput("midreset rx_valid", int'(rx_valid), 0);
      checkOutput("midreset rx_status", int'(rx_status), 0);
      checkOutput("midreset frame_err", int'(frame_err), 0);
      checkOutput("midreset overrun", int'(overrun), 0);
      repeat (5) @(posedge sys_clk);
      #1 rst = 1'b1;
      idleCycles(16 * DIV_9600);
      takeSnapshot();
      applyStimulus(8'h5A, 1'b1, 1'b0, DIV_9600);
      idleCycles(2 * 16 * DIV_9600);
      checkOutput("post-reset valid", valid_rises - v0, 1);
      checkOutput("post-reset byte", int'(last_byte), 'h5A);
      checkOutput("post-reset frame_err", frame_errs - f0, 0);

      // Baud select changes mid-frame must not disturb the frame in flight.
      sel_baud = 2'b00;
      takeSnapshot();
      fork
         applyStimulus(8'h96, 1'b1, 1'b0, DIV_4800);
         begin
            repeat (2 * 16 * DIV_4800) @(posedge sys_clk);
            #1 sel_baud = 2'b11;
         end
      join
      idleCycles(2 * 16 * DIV_4800);
      checkOutput("latched baud valid", valid_rises - v0, 1);
      checkOutput("latched baud byte", int'(last_byte), 'h96);
      checkOutput("latched baud status cycles", status_cycles - s0, STOP_TICK * DIV_4800);
      applyStimulus(8'h4B, 1'b1, 1'b0, DIV_115200);
      idleCycles(2 * 16 * DIV_115200);
      checkOutput("new baud valid", valid_rises - v0, 2);
      checkOutput("new baud byte", int'(last_byte), 'h4B);

`ifdef UART_RX_PARITY_EN
      // Even parity: 8'h07 needs parity bit 1.
      sel_baud = 2'b01;
      takeSnapshot();
      applyStimulus(8'h07, 1'b1, 1'b1, DIV_9600);
      idleCycles(2 * 16 * DIV_9600);
      checkOutput("parity bad pulse", parity_errs - p0, 1);
      checkOutput("parity bad no valid", valid_rises - v0, 0);
      applyStimulus(8'h07, 1'b1, 1'b0, DIV_9600);
      idleCycles(2 * 16 * DIV_9600);
      checkOutput("parity good valid", valid_rises - v0, 1);
      checkOutput("parity good byte", int'(last_byte), 'h07);
      checkOutput("parity good no pulse", parity_errs - p0, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
